// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and op-class helpers.
// MD_UNIT_MADD_EN enables the multiply-accumulate family (MADD/MADDU/MSUB/MSUBU).
package md_unit_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } md_op_e;

    function automatic logic is_mul(input logic [3:0] op);
`ifdef MD_UNIT_MADD_EN
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return op inside {OP_MULT, OP_MULTU};
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return op inside {OP_MTHI, OP_MTLO};
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational result generator: {HI,LO} value for a mul/div/accumulate op.
// MD_UNIT_MADD_EN adds the accumulate cases on top of the acc input.
module md_unit_calc
    import md_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]        op,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [2*XLEN-1:0] acc,
    output logic [2*XLEN-1:0] result
);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   quo_mag;
    logic [XLEN-1:0]   rem_mag;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        // The low 2*XLEN bits of the product of sign-extended operands equal the signed product.
        a_ext   = signed_op ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
        b_ext   = signed_op ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
        product = a_ext * b_ext;

        a_neg   = signed_op & src_a[XLEN-1];
        b_neg   = signed_op & src_b[XLEN-1];
        mag_a   = a_neg ? -src_a : src_a;
        mag_b   = b_neg ? -src_b : src_b;
        quo_mag = '0;
        rem_mag = '0;
        if (mag_b != '0) begin
            quo_mag = mag_a / mag_b;
            rem_mag = mag_a % mag_b;
        end
        quo = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
        rem = a_neg ? -rem_mag : rem_mag;

        case (op)
            OP_MULT, OP_MULTU: result = product;
            OP_DIV, OP_DIVU: begin
                if (src_b == '0)
                    result = {src_a, {XLEN{1'b1}}};
                else if (op == OP_DIV && src_a == MOST_NEG && src_b == {XLEN{1'b1}})
                    result = {{XLEN{1'b0}}, src_a};
                else
                    result = {rem, quo};
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD, OP_MADDU: result = acc + product;
            OP_MSUB, OP_MSUBU: result = acc - product;
`endif
            default: result = '0;
        endcase
    end

`ifndef MD_UNIT_MADD_EN
    logic unused_acc;
    assign unused_acc = ^acc;
`endif

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, cancel and done pulse.
// MD_UNIT_MADD_EN enables the multiply-accumulate ops (decoded in md_unit_pkg).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0]  counter_reg, counter_next;
    logic [2*XLEN-1:0] pending_reg, pending_next;
    logic [XLEN-1:0]   hi_reg, hi_next;
    logic [XLEN-1:0]   lo_reg, lo_next;
    logic              done_reg, done_next;
    logic [2*XLEN-1:0] calc_result;

    md_unit_calc #(.XLEN(XLEN)) u_calc (
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .acc    ({hi_reg, lo_reg}),
        .result (calc_result)
    );

    assign busy = (counter_reg != '0);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    always_comb begin
        counter_next = counter_reg;
        pending_next = pending_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = 1'b0;
        if (busy) begin
            // New starts are ignored while in flight; cancel beats the final writeback.
            if (cancel) begin
                counter_next = '0;
            end else if (counter_reg == CNT_W'(1)) begin
                {hi_next, lo_next} = pending_reg;
                counter_next       = '0;
                done_next          = 1'b1;
            end else begin
                counter_next = counter_reg - CNT_W'(1);
            end
        end else if (start && !cancel) begin
            if (is_mul(op)) begin
                pending_next = calc_result;
                counter_next = CNT_W'(MUL_CYCLES);
            end else if (is_div(op)) begin
                pending_next = calc_result;
                counter_next = CNT_W'(DIV_CYCLES);
            end else if (is_mt(op)) begin
                if (op == OP_MTHI)
                    hi_next = src_a;
                else
                    lo_next = src_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_reg <= '0;
            pending_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            counter_reg <= counter_next;
            pending_reg <= pending_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; successor to the fixed-latency 32-bit HILO unit in the E stage of the 5-stage pipeline.
- Generalised in datapath width and per-class latency; adds `cancel` for exception flush, a completion pulse, and defined divide-by-zero/overflow results.
- The pipeline stalls any MD-class instruction in D while `start | busy`.

Parameters:
- XLEN, 32, operand/HI/LO width; must be ≥ 2.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-family when enabled); must be ≥ 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥ 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; `op` and operands sampled on this edge
- op  in  4  operation code (package enum)
- src_a  in  XLEN  rs operand / dividend / MTHI-MTLO data
- src_b  in  XLEN  rt operand / divisor
- cancel  in  1  abort in-flight operation (exception flush)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse in the cycle HI/LO first show a new result
- hi  out  XLEN  HI register (MFHI source)
- lo  out  XLEN  LO register (MFLO source)

Behaviour:
- Reset: hi = 0, lo = 0, busy = 0, done = 0, counter = 0, pending result cleared. Reset mid-operation abandons it; HI/LO still go to 0.
- Ops:
  - OP_NONE: no effect.
  - OP_MULT / OP_MULTU: {HI,LO} = signed/unsigned 2·XLEN product.
  - OP_DIV / OP_DIVU: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - OP_MTHI / OP_MTLO: single-cycle; HI or LO = src_a at the start edge. busy stays 0 and done stays 0.
  - Undefined codes behave as OP_NONE.
- Latency and counter:
  - Mul/div start: result computed from the sampled operands into a pending 2·XLEN register; counter loaded with MUL_CYCLES or DIV_CYCLES.
  - busy = (counter ≠ 0), so busy is high for exactly N cycles after the start edge.
  - On the edge where counter == 1: HI/LO ← pending, counter ← 0, done ← 1 for one cycle.
  - HI/LO hold their old values while busy.
- Divide by zero: LO = all ones, HI = src_a. No trap.
- Signed overflow (DIV, src_a = most-negative value, src_b = −1): LO = src_a, HI = 0.
- start while busy: ignored; the in-flight op is unaffected. Includes MTHI/MTLO.
- cancel:
  - While busy: counter ← 0 next edge, HI/LO unchanged, no done pulse.
  - cancel and start in the same cycle: cancel wins, start is dropped.
  - cancel on the final (counter == 1) edge: cancel wins, no writeback.
  - cancel while idle: no effect.
- reset has priority over cancel, which has priority over start.
- Arithmetic: signed ops use sign extension to 2·XLEN and are width-generic. No dependence on XLEN = 32.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- Defined: OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU compute {HI,LO} ± (signed/unsigned src_a·src_b), modulo 2^(2·XLEN).
  - The accumulate base is {HI,LO} sampled at the start edge.
  - These ops take MUL_CYCLES and follow the same busy/done/cancel rules.
- Undefined: these four codes decode as OP_NONE.

Decomposition:
- Package md_unit_pkg:
  - 4-bit op enum: OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - is_mul / is_div / is_mt classification functions.
- One sub-module, md_unit_calc:
  - Combinational; takes op, src_a, src_b, {hi,lo} and produces the 2·XLEN pending result.
  - Handles the divide-by-zero, overflow and MADD cases.
  - The top level keeps the counter, HI/LO, the pending register and control.

Test Plan:
- Multiply, signed: reset, then MULT with src_a = 0xFFFFFFFE (−2), src_b = 3 → busy high exactly 5 cycles; done pulses once; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- Divide, signed: DIV with src_a = −7, src_b = 2 → busy 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Same operands with DIVU → LO = 0x7FFFFFFC, HI = 1.
- Divide-by-zero and overflow: DIV with src_a = 5, src_b = 0 → LO = 0xFFFFFFFF, HI = 5. DIV with src_a = 0x80000000, src_b = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Move-to and start while busy: MTHI with src_a = 0x1234 → hi = 0x1234 next cycle, busy 0. Then MULT 6×7, and MTLO 0x55 on cycle 2 of busy → MTLO ignored; final LO = 42, HI = 0.
- Cancel: DIV 100/3, cancel on the 4th busy cycle → busy low next cycle, no done, HI/LO keep their prior values. cancel + start in the same cycle → no operation starts.
- Reset mid-op, then MADD: reset asserted mid-MULT → hi = lo = 0, busy = 0. With MD_UNIT_MADD_EN defined: {HI,LO} = 0:10, MADD 2×3 → LO = 16.
